// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// The state decode helpers keep the registered status outputs consistent with the FSM.
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int CSUM_W     = 8;
    localparam int LEN_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    // States in which a stream byte may be accepted.
    function automatic logic takes_byte(input state_t s);
        return s inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
    endfunction

    // A session is in progress from the first length byte up to the checksum byte.
    function automatic logic is_busy(input state_t s);
        return s inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE, ST_CSUM};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus IMEM write port of the loader.
// master: the loader (drives byte_ready and the RAM port); slave: stream source / IMEM side.
interface imem_loader_if #(
    parameter int ADDR_W = 16
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_wen;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output ram_addr,
        output ram_wdata,
        output ram_wen
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  ram_addr,
        input  ram_wdata,
        input  ram_wen
    );
endinterface

// File: rtl/imem_word_packer.sv
// Assembles payload bytes into little-endian words and keeps the running 8-bit checksum.
// `word` and `full` look ahead at the byte being pushed so the caller can register the word on the same edge.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    push,
    input  logic [7:0]              data,
    output logic [WORD_BYTES*8-1:0] word,
    output logic                    full,
    output logic [CSUM_W-1:0]       sum
);

    logic [1:0]        idx_reg;
    logic [CSUM_W-1:0] sum_reg;

    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            logic [7:0] lane_reg;
            logic       hit;

            assign hit = push && (idx_reg == 2'(gi));

            always_ff @(posedge clk) begin
                if (!rst_n || clear) begin
                    lane_reg <= '0;
                end else if (hit) begin
                    lane_reg <= data;
                end
            end

            assign word[gi*8 +: 8] = hit ? data : lane_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            idx_reg <= '0;
            sum_reg <= '0;
        end else if (push) begin
            idx_reg <= idx_reg + 2'd1;
            sum_reg <= sum_reg + data;
        end
    end

    assign full = push && (idx_reg == 2'(WORD_BYTES - 1));
    assign sum  = sum_reg;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, checksummed byte stream and writes the words into IMEM
// while holding the core in reset. Every output is a register loaded from the next-state decode.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 16384
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    imem_loader_if.master    bus,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] word_count
);

    localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

    state_t                  state_reg, state_next;
    logic [LEN_W-1:0]        len_reg, len_next;
    logic [LEN_W-1:0]        count_reg, count_next;
    logic [ADDR_W-1:0]       addr_reg, addr_next;
    logic [31:0]             wdata_reg, wdata_next;
    logic                    ready_reg, wen_reg, hold_reg, busy_reg, done_reg, err_reg;

    logic                    accept;
    logic [LEN_W-1:0]        len_full;
    logic                    pack_clear, pack_push, pack_full;
    logic [WORD_BYTES*8-1:0] pack_word;
    logic [CSUM_W-1:0]       pack_sum;

    assign accept   = bus.byte_valid && ready_reg;
    assign len_full = {bus.byte_data, len_reg[7:0]};

    imem_word_packer u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pack_clear),
        .push  (pack_push),
        .data  (bus.byte_data),
        .word  (pack_word),
        .full  (pack_full),
        .sum   (pack_sum)
    );

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        count_next = count_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        pack_clear = 1'b0;
        pack_push  = 1'b0;

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next = ST_LEN_LO;
                    count_next = '0;
                    pack_clear = 1'b1;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_next   = {len_reg[LEN_W-1:8], bus.byte_data};
                    state_next = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_next = len_full;
                    if (len_full == '0 || 32'(len_full) > MAX_WORDS_U) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    pack_push = 1'b1;
                    // The 4th byte completes the word; capture it for the single write cycle.
                    if (pack_full) begin
                        wdata_next = pack_word;
                        addr_next  = BASE_ADDR + ADDR_W'({count_reg, 2'b00});
                        state_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                count_next = count_reg + 1'b1;
                state_next = (count_next == len_reg) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                if (accept) begin
                    state_next = (bus.byte_data == pack_sum) ? ST_DONE : ST_ERR;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            len_reg   <= '0;
            count_reg <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            ready_reg <= 1'b0;
            wen_reg   <= 1'b0;
            hold_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            count_reg <= count_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            ready_reg <= takes_byte(state_next);
            wen_reg   <= (state_next == ST_WRITE);
            // The core stays held after an error so a half-loaded image never runs.
            hold_reg  <= is_busy(state_next) || (state_next == ST_ERR);
            busy_reg  <= is_busy(state_next);
            done_reg  <= (state_next == ST_DONE);
            err_reg   <= (state_next == ST_ERR);
        end
    end

    assign bus.byte_ready = ready_reg;
    assign bus.ram_wen    = wen_reg;
    assign bus.ram_addr   = addr_reg;
    assign bus.ram_wdata  = wdata_reg;
    assign cpu_hold       = hold_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign err            = err_reg;
    assign word_count     = count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (BASE_ADDR 0 and 0x0100) share one stream; a byte-position
// model predicts every output each cycle, and literal expectations pin the model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(16)) bus0 ();
    imem_loader_if #(.ADDR_W(16)) bus1 ();

    assign bus0.byte_valid = byte_valid;
    assign bus0.byte_data  = byte_data;
    assign bus1.byte_valid = byte_valid;
    assign bus1.byte_data  = byte_data;

    logic        hold0, busy0, done0, err0, hold1, busy1, done1, err1;
    logic [15:0] wc0, wc1;

    imem_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000), .MAX_WORDS(16384)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus0),
        .cpu_hold(hold0), .busy(busy0), .done(done0), .err(err0), .word_count(wc0)
    );

    imem_loader #(.ADDR_W(16), .BASE_ADDR(16'h0100), .MAX_WORDS(16384)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus1),
        .cpu_hold(hold1), .busy(busy1), .done(done1), .err(err1), .word_count(wc1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: position of the next byte in the session, plus the outputs it implies.
    bit          m_active, m_done, m_err, m_wen;
    int          m_wc, m_pos;
    logic [15:0] m_len, m_addr0, m_addr1;
    logic [7:0]  m_sum;
    logic [31:0] m_word, m_wdata;

    logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
    bit          cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return 'x;
    endfunction

    task automatic model_step();
        bit acc, nwen;
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_err = 0; m_wen = 0; m_wc = 0; m_pos = 0;
            m_len = '0; m_sum = '0; m_word = '0; m_wdata = '0; m_addr0 = '0; m_addr1 = '0;
            return;
        end
        acc  = byte_valid && m_active && !m_wen;
        nwen = 0;
        if (m_wen) m_wc++;
        if (!m_active && start) begin
            m_active = 1; m_done = 0; m_err = 0; m_wc = 0; m_pos = 0; m_sum = '0;
        end else if (acc) begin
            if (m_pos == 0) begin
                m_len[7:0] = byte_data;
            end else if (m_pos == 1) begin
                m_len[15:8] = byte_data;
                if (m_len == 0 || m_len > 16384) begin
                    m_active = 0; m_err = 1;
                end
            end else if (m_pos < 2 + 4 * int'(m_len)) begin
                m_word = {byte_data, m_word[31:8]};
                m_sum  = m_sum + byte_data;
                if ((m_pos - 2) % 4 == 3) begin
                    nwen    = 1;
                    m_wdata = m_word;
                    m_addr0 = 16'(4 * ((m_pos - 2) / 4));
                    m_addr1 = 16'h0100 + m_addr0;
                end
            end else begin
                m_active = 0;
                if (byte_data == m_sum) m_done = 1;
                else m_err = 1;
            end
            m_pos++;
        end
        m_wen = nwen;
    endtask

    task automatic check_dut(input string t, input logic rdy, input logic wen, input logic [15:0] addr,
                             input logic [31:0] wdata, input logic hold, input logic bsy,
                             input logic dn, input logic er, input logic [15:0] wc,
                             input logic [15:0] exp_addr);
        chk({t, ".byte_ready"}, 32'(rdy), 32'(m_active && !m_wen));
        chk({t, ".ram_wen"}, 32'(wen), 32'(m_wen));
        chk({t, ".ram_addr"}, 32'(addr), 32'(exp_addr));
        chk({t, ".ram_wdata"}, wdata, m_wdata);
        chk({t, ".cpu_hold"}, 32'(hold), 32'(m_active || m_err));
        chk({t, ".busy"}, 32'(bsy), 32'(m_active));
        chk({t, ".done"}, 32'(dn), 32'(m_done));
        chk({t, ".err"}, 32'(er), 32'(m_err));
        chk({t, ".word_count"}, 32'(wc), 32'(m_wc));
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                check_dut("d0", bus0.byte_ready, bus0.ram_wen, bus0.ram_addr, bus0.ram_wdata,
                          hold0, busy0, done0, err0, wc0, m_addr0);
                check_dut("d1", bus1.byte_ready, bus1.ram_wen, bus1.ram_addr, bus1.ram_wdata,
                          hold1, busy1, done1, err1, wc1, m_addr1);
                if (bus0.ram_wen === 1'b1) begin
                    wa0.push_back(32'(bus0.ram_addr)); wd0.push_back(bus0.ram_wdata);
                    $display("WRITE d0 addr=%h data=%h", bus0.ram_addr, bus0.ram_wdata);
                end
                if (bus1.ram_wen === 1'b1) begin
                    wa1.push_back(32'(bus1.ram_addr)); wd1.push_back(bus1.ram_wdata);
                    $display("WRITE d1 addr=%h data=%h", bus1.ram_addr, bus1.ram_wdata);
                end
            end
            model_step();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                byte_valid = 1'b0;
                start = ($urandom_range(0, 2) == 0);
                tick();
                start = 1'b0;
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            acc = bus0.byte_ready;
            tick();
            if (acc) break;
        end
        chk("byte_accepted", 32'(acc), 32'd1);
        byte_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit gaps);
        foreach (s[i]) send_byte(s[i], gaps);
    endtask

    task automatic main_seq();
        logic [7:0] one_word[$]  = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        logic [7:0] two_words[$] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                                     8'h13, 8'h01, 8'h10, 8'h00, 8'h07};
        logic [7:0] bad_csum[$]  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                                     8'h13, 8'h01, 8'h10, 8'h00, 8'h08};
        int n0, n1;

        repeat (2) tick();
        cmp_on = 1'b1;
        chk("rst.byte_ready", 32'(bus0.byte_ready), 32'd0);
        chk("rst.ram_wdata", bus0.ram_wdata, 32'd0);
        chk("rst.cpu_hold", 32'(hold0), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single word at BASE_ADDR 0.
        n0 = wa0.size();
        pulse_start();
        send_stream(one_word, 1'b0);
        repeat (2) tick();
        chk("one.nwrites", 32'(wa0.size() - n0), 32'd1);
        chk("one.addr", at(wa0, n0), 32'h0000);
        chk("one.data", at(wd0, n0), 32'h0000_0013);
        chk("one.done", 32'(done0), 32'd1);
        chk("one.word_count", 32'(wc0), 32'd1);
        chk("one.cpu_hold", 32'(hold0), 32'd0);

        // Two words at BASE_ADDR 0x0100.
        n1 = wa1.size();
        pulse_start();
        send_stream(two_words, 1'b0);
        repeat (2) tick();
        chk("two.addr0", at(wa1, n1), 32'h0100);
        chk("two.data0", at(wd1, n1), 32'h0050_0093);
        chk("two.addr1", at(wa1, n1 + 1), 32'h0104);
        chk("two.data1", at(wd1, n1 + 1), 32'h0010_0113);
        chk("two.done", 32'(done1), 32'd1);

        // Bad checksum: writes stay, error latched, core held.
        n1 = wa1.size();
        pulse_start();
        send_stream(bad_csum, 1'b0);
        repeat (2) tick();
        chk("csum.nwrites", 32'(wa1.size() - n1), 32'd2);
        chk("csum.err", 32'(err1), 32'd1);
        chk("csum.done", 32'(done1), 32'd0);
        chk("csum.cpu_hold", 32'(hold1), 32'd1);
        chk("csum.word_count", 32'(wc1), 32'd2);

        // Zero length: ERR right after LEN_HI, no write.
        n0 = wa0.size();
        pulse_start();
        chk("len0.err_cleared", 32'(err0), 32'd0);
        send_stream('{8'h00, 8'h00}, 1'b0);
        chk("len0.err", 32'(err0), 32'd1);
        repeat (3) tick();
        chk("len0.nwrites", 32'(wa0.size() - n0), 32'd0);

        // Length 16385 exceeds the image limit.
        pulse_start();
        send_stream('{8'h01, 8'h40}, 1'b0);
        chk("lenmax.err", 32'(err0), 32'd1);
        repeat (3) tick();
        chk("lenmax.nwrites", 32'(wa0.size() - n0), 32'd0);

        // Source gaps with stray start pulses mid-session.
        n1 = wa1.size();
        pulse_start();
        send_stream(two_words, 1'b1);
        repeat (2) tick();
        chk("bp.data0", at(wd1, n1), 32'h0050_0093);
        chk("bp.addr1", at(wa1, n1 + 1), 32'h0104);
        chk("bp.data1", at(wd1, n1 + 1), 32'h0010_0113);
        chk("bp.done", 32'(done1), 32'd1);

        // Reset after two payload bytes discards the partial word.
        n0 = wa0.size();
        pulse_start();
        send_stream('{8'h01, 8'h00, 8'h13, 8'h00}, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("midrst.busy", 32'(busy0), 32'd0);
        chk("midrst.byte_ready", 32'(bus0.byte_ready), 32'd0);
        chk("midrst.ram_addr", 32'(bus0.ram_addr), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("midrst.nwrites", 32'(wa0.size() - n0), 32'd0);
        pulse_start();
        send_stream(one_word, 1'b0);
        repeat (2) tick();
        chk("reload.addr", at(wa0, n0), 32'h0000);
        chk("reload.data", at(wd0, n0), 32'h0000_0013);
        chk("reload.done", 32'(done0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    initial begin
        fork
            compare_loop();
            main_seq();
        join_any
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
